// File: rtl/ascon_perm_if.sv
// ascon_perm_seq handshake and state bus.
// master drives requests, slave returns the state and status.
interface ascon_perm_if;
  logic             start_i;
  logic [3:0]       nb_rounds_i;
  logic [0:4][63:0] state_i;
  logic [0:4][63:0] state_o;
  logic             busy_o;
  logic             done_o;
  logic [3:0]       round_o;

  modport master (
    output start_i,
    output nb_rounds_i,
    output state_i,
    input  state_o,
    input  busy_o,
    input  done_o,
    input  round_o
  );

  modport slave (
    input  start_i,
    input  nb_rounds_i,
    input  state_i,
    output state_o,
    output busy_o,
    output done_o,
    output round_o
  );
endinterface

// File: rtl/ascon_perm_seq.sv
// Iterated ASCON permutation: one round per clock.
// Round = constant add, substitution (ascon_ps), linear diffusion.

// Bitsliced 5-bit ASCON S-box applied to all 64 columns.
module ascon_ps (
  input  logic [0:4][63:0] pre,
  output logic [0:4][63:0] post
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  assign a0 = pre[0] ^ pre[4];
  assign a1 = pre[1];
  assign a2 = pre[2] ^ pre[1];
  assign a3 = pre[3];
  assign a4 = pre[4] ^ pre[3];

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign post[0] = b0 ^ b4;
  assign post[1] = b1 ^ b0;
  assign post[2] = ~b2;
  assign post[3] = b3 ^ b2;
  assign post[4] = b4;
endmodule

module ascon_perm_seq #(
  parameter int MAX_ROUNDS = 12
) (
  input logic        clock_i,
  input logic        resetb_i,
  ascon_perm_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST = 4'(MAX_ROUNDS - 1);

  logic [0:0]       fsm;
  logic [3:0]       idx;
  logic             done_q;
  logic [0:4][63:0] state_q;

  logic [3:0]       n_eff;
  logic [0:4][63:0] s_c;
  logic [0:4][63:0] s_s;
  logic [0:4][63:0] s_l;

  function automatic logic [63:0] rotr(
    input logic [63:0] v,
    input int unsigned r
  );
    logic [127:0] w;
    w = {v, v} >> r;
    return w[63:0];
  endfunction

  // Oversized round requests run the full table.
  assign n_eff = (bus.nb_rounds_i > MAXR) ? MAXR
                                          : bus.nb_rounds_i;

  // Round constant lands on the low byte of S2.
  always_comb begin
    s_c = state_q;
    s_c[2][7:0] = state_q[2][7:0] ^ {4'hF - idx, idx};
  end

  ascon_ps u_ps (
    .pre  (s_c),
    .post (s_s)
  );

  // Linear diffusion, one rotation pair per word.
  always_comb begin
    s_l[0] = s_s[0] ^ rotr(s_s[0], 19) ^ rotr(s_s[0], 28);
    s_l[1] = s_s[1] ^ rotr(s_s[1], 61) ^ rotr(s_s[1], 39);
    s_l[2] = s_s[2] ^ rotr(s_s[2], 1)  ^ rotr(s_s[2], 6);
    s_l[3] = s_s[3] ^ rotr(s_s[3], 10) ^ rotr(s_s[3], 17);
    s_l[4] = s_s[4] ^ rotr(s_s[4], 7)  ^ rotr(s_s[4], 41);
  end

  // Load on start, iterate rounds, pulse done on the last one.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm     <= IDLE;
      idx     <= '0;
      done_q  <= 1'b0;
      state_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= bus.state_i;
            if (n_eff == 4'd0) begin
              done_q <= 1'b1;
            end else begin
              fsm <= RUN;
              idx <= MAXR - n_eff;
            end
          end
        end
        RUN: begin
          state_q <= s_l;
          if (idx == LAST) begin
            fsm    <= IDLE;
            idx    <= '0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: begin
          fsm <= IDLE;
          idx <= '0;
        end
      endcase
    end
  end

  assign bus.state_o = state_q;
  assign bus.busy_o  = (fsm == RUN);
  assign bus.done_o  = done_q;
  assign bus.round_o = (fsm == RUN) ? idx : 4'd0;
endmodule

// File: doc/ascon_perm_seq.md
Name: ascon_perm_seq

Overview:
Iterated ASCON permutation engine, placed directly downstream of the substitution layer Ps. It holds the 320-bit state in a register and computes one round per clock: constant addition, then Ps (instantiated, not re-implemented), then the linear diffusion layer (implemented in this block). A start/done handshake lets the top-level AEAD FSM run p12 or p8 on a loaded state.

Parameters:
MAX_ROUNDS, 12, total round-constant table length; the first round executed is index MAX_ROUNDS-n.

Ports:
clock_i  input  1  system clock, rising edge
resetb_i  input  1  asynchronous active-low reset
start_i  input  1  request a permutation run; sampled only when the block is ready
nb_rounds_i  input  4  number of rounds n, sampled with start_i
state_i  input  type_state (5x64)  state loaded on accepted start
state_o  output  type_state (5x64)  state register, driven directly
busy_o  output  1  high while rounds are in progress
done_o  output  1  one-cycle pulse when state_o holds the final result
round_o  output  4  current round index, for debug

Behaviour:
- Reset (asynchronous, resetb_i=0):
  - state register = 0; FSM = IDLE; round index = 0.
  - busy_o = 0, done_o = 0, round_o = 0.
  - Applies immediately, including mid-run; the run is abandoned and no done_o is produced.
- FSM states:
  - IDLE: start_i=1 accepted. State register <= state_i, idx <= MAX_ROUNDS-n, go to RUN, busy_o=1 from the next cycle.
  - RUN: every edge, state <= Pl(Ps(Pc(state, idx))), then idx <= idx+1.
    - When the round with idx=MAX_ROUNDS-1 is written, go to IDLE and assert done_o for exactly one cycle.
- Latency: with start accepted at edge k, rounds are written at edges k+1..k+n.
  - done_o=1 and busy_o=0 in the cycle after edge k+n.
  - state_o holds the result from then until the next accepted start.
- Back-to-back: start_i in the done_o cycle is accepted; done_o and start acceptance may coincide.
- start_i while busy_o=1 is ignored; the run is unaffected.
- nb_rounds_i handling:
  - Values 13..15 are clamped to 12.
  - Value 0 loads state_i, skips RUN, and pulses done_o in the next cycle with the state unchanged.
- Constant addition: S2[7:0] ^= {4'hF - idx[3:0], idx[3:0]}.
  - Constants for idx 0..11: F0 E1 D2 C3 B4 A5 96 87 78 69 5A 4B.
  - All other bits pass through.
- Linear layer (>>> is 64-bit rotate right):
  - S0 ^= (S0>>>19) ^ (S0>>>28)
  - S1 ^= (S1>>>61) ^ (S1>>>39)
  - S2 ^= (S2>>>1) ^ (S2>>>6)
  - S3 ^= (S3>>>10) ^ (S3>>>17)
  - S4 ^= (S4>>>7) ^ (S4>>>41)
- round_o = idx during RUN, 0 in IDLE.
- No combinational path from any input to any output.

Test Plan:
1. Reset behaviour: resetb_i=0 asynchronously at mid-clock with start_i=1 and state_i nonzero -> all outputs 0 immediately. After release, busy_o=0 and state_o=0 until a start is accepted.
2. p12 run:
   - Stimulus: state_i = {00001000808C0001, 6CB10AD9CA912F80, 691AED630E8190EF, 0C4C36A20853217C, 46487B3E06D9D7A8}, nb_rounds_i=12.
   - Expected: round_o steps 0..11; done_o pulses exactly 12 cycles after start; state_o matches the golden C model of p12.
   - Also check: intermediate state_o after the first round equals golden Pl(Ps(Pc(S,0))), with the S2 low byte XORed with F0.
3. p8 run on the same state -> round_o steps 4..11 (constants B4..4B); done_o after 8 cycles; result matches the golden p8.
4. Handshake corner cases:
   - start_i pulsed at cycles 3 and 5 of a p12 run -> both ignored; exactly one done_o.
   - start_i asserted in the done_o cycle with n=8 -> second run accepted, done_o 8 cycles later.
5. nb_rounds_i corner cases:
   - nb_rounds_i=0 -> done_o on the next cycle with state_o=state_i.
   - nb_rounds_i=15 -> behaves exactly as 12 (same result and latency).
6. Reset mid-run: resetb_i low at round 6 of p12 -> state_o=0 and busy_o=0 immediately; no done_o. A fresh p12 run afterwards gives the correct golden result.
